stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_unit.sv | 118 +++++++++++
 tb/tb_stack_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// LIFO stack: a 2**ADDR_W-word memory with a downward-growing stack pointer,
// occupancy tracking, sticky overflow/underflow flags and a small control FSM.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              PUSH,
    input  logic              POP,
    input  logic              SP_LD,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              FULL,
    output logic              EMPTY,
    output logic              OVF,
    output logic              UNF
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, POP_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_dec;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_data_p0;
    logic [DATA_W-1:0] rd_data_p1;
    logic              acc_ld, acc_push, ovf_set, unf_set;

    assign sp_dec = sp - ADDR_W'(1);
    assign SP_OUT = sp;
    assign BUSY   = (state != IDLE);
    assign FULL   = (cnt == CNT_MAX);
    assign EMPTY  = (cnt == '0);

    // Request arbitration happens only in IDLE; anything raised while busy is dropped.
    always_comb begin
        state_nxt = state;
        acc_ld    = 1'b0;
        acc_push  = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (state)
            IDLE: begin
                if (SP_LD) begin
                    acc_ld = 1'b1;
                end else if (PUSH) begin
                    if (FULL) begin
                        ovf_set = 1'b1;
                    end else begin
                        acc_push  = 1'b1;
                        state_nxt = PUSH_WR;
                    end
                end else if (POP) begin
                    if (EMPTY) begin
                        unf_set = 1'b1;
                    end else begin
                        state_nxt = POP_RD;
                    end
                end
            end
            PUSH_WR:  state_nxt = IDLE;
            POP_RD:   state_nxt = POP_DONE;
            POP_DONE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state    <= IDLE;
            sp       <= '0;
            cnt      <= '0;
            DATA_OUT <= '0;
            DONE     <= 1'b0;
            OVF      <= 1'b0;
            UNF      <= 1'b0;
        end else begin
            state <= state_nxt;
            DONE  <= 1'b0;
            if (acc_ld) begin
                sp  <= ADDR_IN;
                cnt <= '0;
                OVF <= 1'b0;
                UNF <= 1'b0;
            end
            if (ovf_set) OVF <= 1'b1;
            if (unf_set) UNF <= 1'b1;
            if (state == PUSH_WR) begin
                sp   <= sp_dec;
                cnt  <= cnt + (ADDR_W+1)'(1);
                DONE <= 1'b1;
            end
            if (state == POP_DONE) begin
                DATA_OUT <= rd_data_p1;
                sp       <= sp + ADDR_W'(1);
                cnt      <= cnt - (ADDR_W+1)'(1);
                DONE     <= 1'b1;
            end
        end
    end

    // Datapath storage carries no reset; a reset edge during PUSH_WR still blocks the write.
    always_ff @(posedge clk) begin
        if (acc_push) wr_data_p0 <= DATA_IN;
        if (RST && state == PUSH_WR) mem[sp_dec] <= wr_data_p0;
        if (state == POP_RD) rd_data_p1 <= mem[sp];
    end

endmodule

// File: tb/tb_stack_unit.sv
// Randomized bench for stack_unit, checked against a transaction-level stack model.
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              RST = 1'b1;
    logic              PUSH = 1'b0, POP = 1'b0, SP_LD = 1'b0;
    logic [DATA_W-1:0] DATA_IN = '0;
    logic [ADDR_W-1:0] ADDR_IN = '0;
    logic [DATA_W-1:0] DATA_OUT;
    logic [ADDR_W-1:0] SP_OUT;
    logic              BUSY, DONE, FULL, EMPTY, OVF, UNF;

    stack_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .RST(RST), .PUSH(PUSH), .POP(POP), .SP_LD(SP_LD),
        .DATA_IN(DATA_IN), .ADDR_IN(ADDR_IN), .DATA_OUT(DATA_OUT),
        .SP_OUT(SP_OUT), .BUSY(BUSY), .DONE(DONE), .FULL(FULL),
        .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the stack as seen from the ports.
    logic [7:0] mem_m [DEPTH];
    int         sp_m, cnt_m;
    logic [7:0] dout_m;
    bit         ovf_m, unf_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_done);
        check({tag, ".sp"},    32'(SP_OUT),   32'(sp_m));
        check({tag, ".dout"},  32'(DATA_OUT), 32'(dout_m));
        check({tag, ".full"},  32'(FULL),     32'(cnt_m == DEPTH));
        check({tag, ".empty"}, 32'(EMPTY),    32'(cnt_m == 0));
        check({tag, ".ovf"},   32'(OVF),      32'(ovf_m));
        check({tag, ".unf"},   32'(UNF),      32'(unf_m));
        check({tag, ".busy"},  32'(BUSY),     32'(0));
        check({tag, ".done"},  32'(DONE),     32'(exp_done));
    endtask

    task automatic idle_inputs();
        PUSH = 1'b0; POP = 1'b0; SP_LD = 1'b0;
    endtask

    task automatic model_reset();
        sp_m = 0; cnt_m = 0; dout_m = 8'h00; ovf_m = 1'b0; unf_m = 1'b0;
    endtask

    task automatic poke_busy();
        PUSH = 1'($urandom); POP = 1'($urandom); SP_LD = 1'($urandom);
        ADDR_IN = 8'($urandom);
    endtask

    // All tasks start and end at a falling edge with request inputs idle.
    task automatic do_reset();
        idle_inputs();
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        model_reset();
        check_outputs("rst", 1'b0);
    endtask

    task automatic do_ld(input logic [7:0] a);
        SP_LD = 1'b1; ADDR_IN = a;
        PUSH = 1'($urandom); POP = 1'($urandom);
        @(negedge clk);
        idle_inputs();
        sp_m = int'(a); cnt_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
        check_outputs("ld", 1'b0);
    endtask

    task automatic do_push(input logic [7:0] d, input bit with_pop, input bit poke);
        PUSH = 1'b1; POP = with_pop; DATA_IN = d;
        @(negedge clk);
        idle_inputs();
        DATA_IN = 8'($urandom);
        if (cnt_m == DEPTH) begin
            ovf_m = 1'b1;
            check_outputs("push_full", 1'b0);
        end else begin
            check("push.busy", 32'(BUSY), 32'(1));
            check("push.early_done", 32'(DONE), 32'(0));
            if (poke) poke_busy();
            @(negedge clk);
            idle_inputs();
            sp_m = (sp_m + DEPTH - 1) % DEPTH;
            mem_m[sp_m] = d;
            cnt_m++;
            check("push.mem", 32'(dut.mem[sp_m]), 32'(d));
            check_outputs("push", 1'b1);
        end
    endtask

    task automatic do_pop(input bit poke);
        POP = 1'b1;
        @(negedge clk);
        idle_inputs();
        if (cnt_m == 0) begin
            unf_m = 1'b1;
            check_outputs("pop_empty", 1'b0);
        end else begin
            check("pop.busy1", 32'(BUSY), 32'(1));
            check("pop.done1", 32'(DONE), 32'(0));
            if (poke) poke_busy();
            @(negedge clk);
            check("pop.busy2", 32'(BUSY), 32'(1));
            check("pop.done2", 32'(DONE), 32'(0));
            if (poke) poke_busy();
            @(negedge clk);
            idle_inputs();
            dout_m = mem_m[sp_m];
            sp_m = (sp_m + 1) % DEPTH;
            cnt_m--;
            check_outputs("pop", 1'b1);
        end
    endtask

    task automatic push_abort(input logic [7:0] d);
        int tgt;
        tgt = (sp_m + DEPTH - 1) % DEPTH;
        PUSH = 1'b1; DATA_IN = d;
        @(negedge clk);
        idle_inputs();
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        model_reset();
        check_outputs("push_abort", 1'b0);
        check("push_abort.mem", 32'(dut.mem[tgt]), 32'(mem_m[tgt]));
    endtask

    task automatic pop_abort(input bit late);
        POP = 1'b1;
        @(negedge clk);
        idle_inputs();
        if (late) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        model_reset();
        check_outputs(late ? "pop_abort_done" : "pop_abort_rd", 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Basic push/pop around SP=0x10, then DATA_OUT must hold.
        do_ld(8'h10);
        do_push(8'hA5, 1'b0, 1'b0);
        do_pop(1'b0);
        @(negedge clk);
        check_outputs("hold", 1'b0);

        // Pointer wrap in both directions.
        do_reset();
        do_push(8'h3C, 1'b0, 1'b0);
        do_pop(1'b0);

        // Underflow, fill to capacity, overflow, then SP_LD clears flags.
        do_reset();
        do_pop(1'b0);
        for (int i = 0; i < DEPTH; i++) do_push(8'($urandom), 1'b0, 1'b0);
        do_push(8'h5A, 1'b0, 1'b0);
        do_pop(1'b0);
        do_ld(8'h00);

        // Simultaneous PUSH+POP and requests while busy.
        do_push(8'hC3, 1'b1, 1'b1);
        do_pop(1'b1);

        // Reset in the middle of operations.
        do_ld(8'h21);
        do_push(8'h77, 1'b0, 1'b0);
        do_ld(8'h21);
        push_abort(8'h99);
        do_push(8'h12, 1'b0, 1'b0);
        pop_abort(1'b0);
        do_push(8'h34, 1'b0, 1'b0);
        do_pop(1'b0);
        do_push(8'h56, 1'b0, 1'b0);
        pop_abort(1'b1);

        // Random mix of operations.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0)       do_ld(8'($urandom));
            else if (r == 1)  do_reset();
            else if (r < 11)  do_push(8'($urandom), 1'($urandom), 1'($urandom));
            else              do_pop(1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
